// File: rtl/mmu_pkg.sv
// Shared types and constants for the mmu_xlate TLB translator: packed TLB entry,
// per-channel response record, exception codes and unmapped-segment encodings.
package mmu_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] paddr;
    logic        uncache;
    logic [1:0]  exc;
  } resp_t;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_REFILL  = 2'b01;
  localparam logic [1:0] EXC_INVALID = 2'b10;
  localparam logic [1:0] EXC_MOD     = 2'b11;

  // VA[31:29]: 0x8/0x9 -> kseg0, 0xA/0xB -> kseg1, everything else is mapped.
  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  localparam logic [2:0] CCA_CACHED = 3'd3;

endpackage

// File: rtl/mmu_tlb_match.sv
// Fully associative compare of the TLB array against one {vpn2, asid} key.
// Lowest matching index wins when software has left duplicate entries.
module mmu_tlb_match
  import mmu_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  tlb_entry_t       entries [TLBNUM],
  input  logic [18:0]      vpn2,
  input  logic [7:0]       asid,
  output logic             hit,
  output logic [IW-1:0]    index,
  output tlb_entry_t       entry
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    hit   = 1'b0;
    index = '0;
    entry = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
        hit   = 1'b1;
        index = IW'(i);
        entry = entries[i];
      end
    end
  end

endmodule

// File: rtl/mmu_xlate.sv
// Multi-channel VA->PA translator with a MIPS32-style paired-page TLB and CP0 ports.
// Optional feature macro: MMU_KSEG0_K0_EN (kseg0 cacheability follows Config.K0).
module mmu_xlate
  import mmu_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int NCH    = 2,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*32-1:0] req_vaddr,
  input  logic [NCH-1:0]    req_store,
  input  logic [NCH-1:0]    stall,
  output logic [NCH-1:0]    resp_valid,
  output logic [NCH*32-1:0] resp_paddr,
  output logic [NCH-1:0]    resp_uncache,
  output logic [NCH*2-1:0]  resp_exc,
  input  logic [7:0]        cur_asid,
  input  logic [2:0]        k0,
  input  logic              we,
  input  logic [IW-1:0]     w_index,
  input  tlb_entry_t        w_entry,
  input  logic [IW-1:0]     r_index,
  output tlb_entry_t        r_entry,
  input  logic              p_valid,
  input  logic [18:0]       p_vpn2,
  input  logic [7:0]        p_asid,
  output logic              p_found,
  output logic [IW-1:0]     p_index
);

  tlb_entry_t    tlb_q [TLBNUM];
  tlb_entry_t    tlb_d [TLBNUM];
  resp_t         resp_q [NCH];
  resp_t         resp_d [NCH];
  tlb_entry_t    r_entry_q, r_entry_d;
  logic          p_found_q, p_found_d;
  logic [IW-1:0] p_index_q, p_index_d;

  logic          ch_hit [NCH];
  tlb_entry_t    ch_entry [NCH];
  logic [IW-1:0] ch_index_unused [NCH];
  logic          probe_hit;
  logic [IW-1:0] probe_index;
  tlb_entry_t    probe_entry_unused;
  logic          kseg0_uncache;

`ifdef MMU_KSEG0_K0_EN
  assign kseg0_uncache = (k0 != CCA_CACHED);
`else
  logic k0_unused;
  assign kseg0_uncache = 1'b0;
  assign k0_unused     = ^k0;
`endif

  function automatic resp_t xlate(input logic [31:0] va, input logic store,
                                  input logic hit, input tlb_entry_t e,
                                  input logic k0_uc);
    resp_t       r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r       = '0;
    r.valid = 1'b1;
    {pfn, c, d, v} = va[12] ? {e.pfn1, e.c1, e.d1, e.v1} : {e.pfn0, e.c0, e.d0, e.v0};
    if (va[31:29] == SEG_KSEG0) begin
      r.paddr   = {1'b0, va[30:0]};
      r.uncache = k0_uc;
    end else if (va[31:29] == SEG_KSEG1) begin
      r.paddr   = {3'b000, va[28:0]};
      r.uncache = 1'b1;
    end else if (!hit) begin
      r.exc = EXC_REFILL;
    end else if (!v) begin
      r.exc = EXC_INVALID;
    end else if (store && !d) begin
      r.exc = EXC_MOD;
    end else begin
      r.paddr   = {pfn, va[11:0]};
      r.uncache = (c != CCA_CACHED);
    end
    return r;
  endfunction

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    mmu_tlb_match #(.TLBNUM(TLBNUM), .IW(IW)) u_match (
      .entries (tlb_q),
      .vpn2    (req_vaddr[32*ch+13 +: 19]),
      .asid    (cur_asid),
      .hit     (ch_hit[ch]),
      .index   (ch_index_unused[ch]),
      .entry   (ch_entry[ch])
    );
  end

  mmu_tlb_match #(.TLBNUM(TLBNUM), .IW(IW)) u_probe (
    .entries (tlb_q),
    .vpn2    (p_vpn2),
    .asid    (p_asid),
    .hit     (probe_hit),
    .index   (probe_index),
    .entry   (probe_entry_unused)
  );

  // Lookups and probes above read tlb_q, so a same-cycle write is not visible.
  always_comb begin
    tlb_d = tlb_q;
    if (we) tlb_d[w_index] = w_entry;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      resp_d[i] = resp_q[i];
      if (!stall[i]) begin
        if (req_valid[i]) begin
          resp_d[i] = xlate(req_vaddr[32*i +: 32], req_store[i], ch_hit[i],
                            ch_entry[i], kseg0_uncache);
        end else begin
          resp_d[i].valid = 1'b0;
        end
      end
    end
  end

  always_comb begin
    r_entry_d = tlb_q[r_index];
    p_found_d = p_found_q;
    p_index_d = p_index_q;
    if (p_valid) begin
      p_found_d = probe_hit;
      p_index_d = probe_hit ? probe_index : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the TLB array is reset explicitly so every entry starts invalid;
      // this keeps it in flops rather than a RAM macro, which is intended here.
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
      for (int i = 0; i < NCH; i++) resp_q[i] <= '0;
      r_entry_q <= '0;
      p_found_q <= 1'b0;
      p_index_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      tlb_q     <= tlb_d;
      resp_q    <= resp_d;
      r_entry_q <= r_entry_d;
      p_found_q <= p_found_d;
      p_index_q <= p_index_d;
    end
  end

  always_comb begin
    resp_valid   = '0;
    resp_paddr   = '0;
    resp_uncache = '0;
    resp_exc     = '0;
    for (int i = 0; i < NCH; i++) begin
      resp_valid[i]         = resp_q[i].valid;
      resp_paddr[32*i +: 32] = resp_q[i].paddr;
      resp_uncache[i]       = resp_q[i].uncache;
      resp_exc[2*i +: 2]    = resp_q[i].exc;
    end
  end

  assign r_entry = r_entry_q;
  assign p_found = p_found_q;
  assign p_index = p_index_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Directed self-checking bench for mmu_xlate (TLBNUM=16, NCH=2).
// Expected kseg0 cacheability follows MMU_KSEG0_K0_EN when the bench is built with it.
module tb_mmu_xlate;
  import mmu_pkg::*;

  localparam int TLBNUM = 16;
  localparam int NCH    = 2;
  localparam int IW     = 4;
`ifdef MMU_KSEG0_K0_EN
  localparam logic K0_UC = 1'b1;
`else
  localparam logic K0_UC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    req_valid, req_store, stall;
  logic [NCH*32-1:0] req_vaddr;
  logic [NCH-1:0]    resp_valid, resp_uncache;
  logic [NCH*32-1:0] resp_paddr;
  logic [NCH*2-1:0]  resp_exc;
  logic [7:0]        cur_asid, p_asid;
  logic [2:0]        k0;
  logic              we, p_valid, p_found;
  logic [IW-1:0]     w_index, r_index, p_index;
  tlb_entry_t        w_entry, r_entry, e3, e3b, e1;
  logic [18:0]       p_vpn2;

  int tests_run    = 0;
  int tests_failed = 0;

  mmu_xlate #(.TLBNUM(TLBNUM), .NCH(NCH)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_store(req_store), .stall(stall),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_uncache(resp_uncache),
    .resp_exc(resp_exc), .cur_asid(cur_asid), .k0(k0),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .p_valid(p_valid), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_found(p_found), .p_index(p_index)
  );

  always #5 clk = ~clk;

  // {valid, paddr, uncache, exc}
  function automatic logic [35:0] resp_of(input int ch);
    return {resp_valid[ch], resp_paddr[32*ch +: 32], resp_uncache[ch], resp_exc[2*ch +: 2]};
  endfunction

  task automatic set_ch(input int ch, input logic v, input logic [31:0] va, input logic st);
    req_valid[ch]          = v;
    req_vaddr[32*ch +: 32] = va;
    req_store[ch]          = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({resp_valid, resp_paddr, resp_uncache, resp_exc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp got %h required 0", {resp_valid, resp_paddr, resp_uncache, resp_exc});
    end
    tests_run++;
    if ({r_entry, p_found, p_index} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cp0 got %h required 0", {r_entry, p_found, p_index});
    end
  endtask

  task automatic test_kseg();
    logic [35:0] exp0, exp1;
    k0 = 3'd2;
    set_ch(0, 1'b1, 32'hBFC0_0000, 1'b0);
    set_ch(1, 1'b1, 32'h8000_1000, 1'b0);
    tick();
    exp0 = {1'b1, 32'h1FC0_0000, 1'b1, EXC_NONE};
    exp1 = {1'b1, 32'h0000_1000, K0_UC, EXC_NONE};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL kseg1_bfc got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL kseg0_k0_2 got %h required %h", resp_of(1), exp1);
    end
    // Segment edges: top of kseg0 with k0 cached, first kseg2 address is mapped.
    k0 = 3'd3;
    set_ch(0, 1'b1, 32'h9FFF_FFFF, 1'b0);
    set_ch(1, 1'b1, 32'hC000_0000, 1'b0);
    tick();
    exp0 = {1'b1, 32'h1FFF_FFFF, 1'b0, EXC_NONE};
    exp1 = {1'b1, 32'h0, 1'b0, EXC_REFILL};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL kseg0_top got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL kseg2_refill got %h required %h", resp_of(1), exp1);
    end
    set_ch(0, 1'b1, 32'h7FFF_FFFF, 1'b0);
    set_ch(1, 1'b1, 32'hB000_0004, 1'b0);
    tick();
    exp0 = {1'b1, 32'h0, 1'b0, EXC_REFILL};
    exp1 = {1'b1, 32'h1000_0004, 1'b1, EXC_NONE};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL kuseg_top got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL kseg1_b got %h required %h", resp_of(1), exp1);
    end
  endtask

  task automatic test_tlb_hit();
    logic [35:0] exp0, exp1;
    e3 = '0;
    e3.vpn2 = 19'h00200; e3.asid = 8'd5; e3.pfn0 = 20'h12345; e3.c0 = 3'd3; e3.v0 = 1'b1;
    we = 1'b1; w_index = 4'd3; w_entry = e3;
    set_ch(0, 1'b0, 32'h0, 1'b0);
    set_ch(1, 1'b0, 32'h0, 1'b0);
    tick();
    we = 1'b0;
    cur_asid = 8'd5;
    r_index  = 4'd3;
    set_ch(0, 1'b1, 32'h0040_0ABC, 1'b0);
    set_ch(1, 1'b1, 32'h0040_0ABC, 1'b1);
    tick();
    exp0 = {1'b1, 32'h1234_5ABC, 1'b0, EXC_NONE};
    exp1 = {1'b1, 32'h0, 1'b0, EXC_MOD};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL tlb_load_hit got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL tlb_store_mod got %h required %h", resp_of(1), exp1);
    end
    tests_run++;
    if (r_entry !== e3) begin
      tests_failed++; $display("FAIL tlbr_idx3 got %h required %h", r_entry, e3);
    end
    cur_asid = 8'd6;
    set_ch(1, 1'b0, 32'h0, 1'b0);
    tick();
    exp0 = {1'b1, 32'h0, 1'b0, EXC_REFILL};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL asid_refill got %h required %h", resp_of(0), exp0);
    end
    cur_asid = 8'd5;
    set_ch(0, 1'b1, 32'h0040_1000, 1'b0);
    tick();
    exp0 = {1'b1, 32'h0, 1'b0, EXC_INVALID};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL odd_invalid got %h required %h", resp_of(0), exp0);
    end
  endtask

  task automatic test_probe();
    p_valid = 1'b1; p_vpn2 = 19'h00200; p_asid = 8'd5;
    tick();
    p_valid = 1'b0; p_asid = 8'd6;
    tests_run++;
    if ({p_found, p_index} !== {1'b1, 4'd3}) begin
      tests_failed++; $display("FAIL probe_hit got %b/%0d required 1/3", p_found, p_index);
    end
    tick();
    tests_run++;
    if ({p_found, p_index} !== {1'b1, 4'd3}) begin
      tests_failed++; $display("FAIL probe_hold got %b/%0d required 1/3", p_found, p_index);
    end
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    tests_run++;
    if ({p_found, p_index} !== {1'b0, 4'd0}) begin
      tests_failed++; $display("FAIL probe_miss got %b/%0d required 0/0", p_found, p_index);
    end
  endtask

  task automatic test_write_collision();
    logic [35:0] exp0;
    e3b = e3; e3b.pfn0 = 20'h54321;
    we = 1'b1; w_index = 4'd3; w_entry = e3b;
    set_ch(0, 1'b1, 32'h0040_0ABC, 1'b0);
    tick();
    we = 1'b0;
    exp0 = {1'b1, 32'h1234_5ABC, 1'b0, EXC_NONE};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL write_same_cycle_old got %h required %h", resp_of(0), exp0);
    end
    tick();
    exp0 = {1'b1, 32'h5432_1ABC, 1'b0, EXC_NONE};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL write_then_new got %h required %h", resp_of(0), exp0);
    end
  endtask

  task automatic test_multi_match();
    logic [35:0] exp0;
    e1 = '0;
    e1.vpn2 = 19'h00200; e1.asid = 8'd77; e1.g = 1'b1; e1.pfn0 = 20'h0AAAA;
    e1.c0 = 3'd2; e1.d0 = 1'b1; e1.v0 = 1'b1;
    we = 1'b1; w_index = 4'd1; w_entry = e1;
    set_ch(0, 1'b0, 32'h0, 1'b0);
    tick();
    we = 1'b0;
    cur_asid = 8'd9;
    set_ch(0, 1'b1, 32'h0040_0ABC, 1'b1);
    tick();
    exp0 = {1'b1, 32'h0AAA_AABC, 1'b1, EXC_NONE};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL global_store got %h required %h", resp_of(0), exp0);
    end
    cur_asid = 8'd5;
    p_valid = 1'b1; p_vpn2 = 19'h00200; p_asid = 8'd5;
    tick();
    p_valid = 1'b0;
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL dup_lowest_lookup got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if ({p_found, p_index} !== {1'b1, 4'd1}) begin
      tests_failed++; $display("FAIL dup_lowest_probe got %b/%0d required 1/1", p_found, p_index);
    end
  endtask

  task automatic test_stall();
    logic [35:0] exp0, exp1;
    set_ch(0, 1'b0, 32'h0, 1'b0);
    set_ch(1, 1'b1, 32'hA000_0010, 1'b0);
    tick();
    exp1 = {1'b1, 32'h0000_0010, 1'b1, EXC_NONE};
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL stall_pre got %h required %h", resp_of(1), exp1);
    end
    stall[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 1'b1, 32'hA000_1000 + 32'(4 * k), 1'b0);
      set_ch(1, 1'b1, 32'h0040_0000 + 32'(k), 1'b1);
      tick();
      exp0 = {1'b1, 32'h0000_1000 + 32'(4 * k), 1'b1, EXC_NONE};
      tests_run++;
      if (resp_of(0) !== exp0) begin
        tests_failed++; $display("FAIL stall_ch0_run%0d got %h required %h", k, resp_of(0), exp0);
      end
      tests_run++;
      if (resp_of(1) !== exp1) begin
        tests_failed++; $display("FAIL stall_ch1_hold%0d got %h required %h", k, resp_of(1), exp1);
      end
    end
    stall[1] = 1'b0;
    set_ch(1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    tick();
    exp1 = {1'b0, 32'h0000_0010, 1'b1, EXC_NONE};
    tests_run++;
    if (resp_of(1) !== exp1) begin
      tests_failed++; $display("FAIL idle_valid_drop got %h required %h", resp_of(1), exp1);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp0;
    set_ch(0, 1'b1, 32'hA000_0020, 1'b0);
    p_valid = 1'b1; p_vpn2 = 19'h00200; p_asid = 8'd5;
    r_index = 4'd1;
    tick();
    p_valid = 1'b0;
    resetn  = 1'b0;
    #2;
    tests_run++;
    if ({resp_valid, resp_paddr, resp_uncache, resp_exc, r_entry, p_found, p_index} !== '0) begin
      tests_failed++; $display("FAIL mid_reset_clear got %h required 0",
                               {resp_valid, resp_paddr, resp_uncache, resp_exc, r_entry, p_found, p_index});
    end
    tick();
    resetn = 1'b1;
    set_ch(0, 1'b1, 32'h0040_0ABC, 1'b0);
    tick();
    exp0 = {1'b1, 32'h0, 1'b0, EXC_REFILL};
    tests_run++;
    if (resp_of(0) !== exp0) begin
      tests_failed++; $display("FAIL tlb_cleared got %h required %h", resp_of(0), exp0);
    end
    tests_run++;
    if (r_entry !== '0) begin
      tests_failed++; $display("FAIL tlbr_cleared got %h required 0", r_entry);
    end
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = '0; req_vaddr = '0; req_store = '0; stall = '0;
    cur_asid = '0; k0 = '0; we = 1'b0; w_index = '0; w_entry = '0;
    r_index = '0; p_valid = 1'b0; p_vpn2 = '0; p_asid = '0;
    e3 = '0; e3b = '0; e1 = '0;
    tick();
    test_reset();
    tick();
    resetn = 1'b1;
    tick();
    test_kseg();
    test_tlb_hit();
    test_probe();
    test_write_collision();
    test_multi_match();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmu_xlate.md
# mmu_xlate

Parametrised, multi-channel virtual-to-physical address translator with a fully associative MIPS32-style TLB (paired even/odd 4 KB pages). It replaces the purely combinational kseg0/kseg1 converter between the fetch/LSU address stages and the cache/AXI front end. Each channel performs a registered, stallable one-cycle lookup. CP0 writes, reads and probes the TLB through dedicated ports (TLBWI/TLBWR/TLBR/TLBP).

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries (power of two, 2..64)
- NCH, 2, number of independent lookup channels (channel 0 = fetch, 1 = data by convention)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NCH  lookup request per channel
- req_vaddr  in  NCH*32  virtual address, channel i at [32i+31:32i]
- req_store  in  NCH  request is a store (dirty check)
- stall  in  NCH  hold channel i output register
- resp_valid  out  NCH  result valid
- resp_paddr  out  NCH*32  physical address
- resp_uncache  out  NCH  access is uncached
- resp_exc  out  NCH*2  00 none, 01 refill, 10 invalid, 11 modified
- cur_asid  in  8  EntryHi.ASID
- k0  in  3  Config.K0 (used only with MMU_KSEG0_K0_EN)
- we  in  1  write entry w_index
- w_index  in  log2(TLBNUM)  write index
- w_entry  in  78  packed tlb_entry_t
- r_index  in  log2(TLBNUM)  read index
- r_entry  out  78  registered read data
- p_valid  in  1  probe request
- p_vpn2  in  19  probe VPN2
- p_asid  in  8  probe ASID
- p_found  out  1  probe hit
- p_index  out  log2(TLBNUM)  probe hit index

## Operation
- Segment decode on VA[31:28]: 8–9 kseg0 → paddr={1'b0,VA[30:0]}, uncache=0; A–B kseg1 → paddr={3'b0,VA[28:0]}, uncache=1; all others mapped via TLB.
- Match: entry.vpn2==VA[31:13] and (entry.g or entry.asid==cur_asid). VA[12] selects odd (1) / even (0) half.
- Hit: paddr={pfn,VA[11:0]}, uncache=(c!=3'd3).
- Exception priority: no match → refill; match with v=0 → invalid; req_store with d=0 → modified. On exception paddr=0, uncache=0.
- Multiple matches (software error): lowest index wins; no exception.
- Write: we=1 updates entry w_index at the clock edge; a lookup or probe in the same cycle sees old contents.
- Read: r_entry registered from entry r_index every cycle.
- Probe: p_valid samples; p_found/p_index are registered next cycle and hold until the next p_valid. Miss gives p_found=0, p_index=0.

## Timing
- Reset: every entry cleared (v0=v1=0, g=0, all fields 0); resp_valid, resp_paddr, resp_uncache, resp_exc, r_entry, p_found, p_index all 0.
- Latency 1: request at cycle T gives a response at T+1 when stall[i]=0 at T.
- stall[i]=1: all channel-i outputs hold their value, and the request at that cycle is ignored; the requester re-presents it.
- stall[i]=0 with req_valid[i]=0: resp_valid[i]←0, other outputs hold.
- Channels are independent; same-cycle lookups on all channels plus a probe are all serviced.
- Reset mid-operation clears everything immediately; there is no pending state.

## Configuration
- MMU_KSEG0_K0_EN defined: kseg0 uncache=(k0!=3'd3).
- MMU_KSEG0_K0_EN undefined: kseg0 is always cached; k0 is ignored.

## Structure
- Package mmu_pkg: tlb_entry_t packed {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1} = 78 bits; exception code constants EXC_NONE/REFILL/INVALID/MOD; segment constants.
- Sub-module mmu_tlb_match: combinational compare of the entry array against one {vpn2, asid}, returning hit/index/entry. It is instantiated NCH+1 times (one per channel plus the probe).

## Test plan
- After reset, lookup VA 0xBFC0_0000 on ch0 → next cycle paddr 0x1FC0_0000, uncache=1, exc=00.
- Write idx 3: vpn2=0x00400>>1 region (VA 0x0040_0000), asid 5, g=0, pfn0=0x12345, c0=3, v0=1, d0=0. With cur_asid=5, load VA 0x0040_0ABC → paddr 0x1234_5ABC, uncache=0. A store to the same VA → exc=11.
- Same entry with cur_asid=6 → exc=01; odd page VA 0x0040_1000 with v1=0 → exc=10.
- Probe vpn2 0x00200/asid 5 → p_found=1, p_index=3 one cycle later; a write to idx 3 in the same cycle as a lookup returns the old result.
- stall[1]=1 for 3 cycles while ch0 keeps issuing requests → ch1 outputs frozen, ch0 responses continue each cycle.
- MMU_KSEG0_K0_EN set with k0=2: VA 0x8000_1000 → paddr 0x0000_1000, uncache=1. Without the macro → uncache=0.
